// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the scoreboard hazard unit (register file geometry, default latencies).
package hazard_scoreboard_pkg;

    // Register index width of the MIPS register file.
    localparam int unsigned REGISTER_BITS    = 5;

    // Extra cycles a load result trails an ALU result (single-cycle data memory).
    localparam int unsigned DEFAULT_LOAD_LAT = 1;

    // Default width of the stall performance counter.
    localparam int unsigned DEFAULT_CNT_W    = 16;

    // Per-register counter width: must hold 1 + load_lat.
    function automatic int unsigned sb_cnt_width(input int unsigned load_lat);
        return $clog2(load_lat + 2);
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: cycles remaining until a register's pending result can be forwarded.
module hazard_sb_entry #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: frozen pipe holds; a new producer overrides aging; otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!hold) begin
            if (load) begin
                cnt_d = load_val;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard unit beside ID: per-register result latency drives hold, bubble and freeze.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_BITS     = REGISTER_BITS,
    parameter int unsigned LOAD_LAT     = DEFAULT_LOAD_LAT,
    parameter int unsigned BRANCH_IN_ID = 1,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                id_kill,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_branch,
    input  logic                id_wr_en,
    input  logic [REG_BITS-1:0] id_wr_reg,
    input  logic                id_is_load,
    input  logic                mem_busy,
    output logic                hold,
    output logic                id_flush,
    output logic                freeze,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam int unsigned NREG  = 1 << REG_BITS;
    localparam int unsigned CW    = sb_cnt_width(LOAD_LAT);
    localparam bit          BR_ID = (BRANCH_IN_ID != 0);

    logic [CW-1:0]    cnt [NREG];
    logic [CW-1:0]    rs_cnt;
    logic [CW-1:0]    rt_cnt;
    logic [CW-1:0]    thr;
    logic [CW-1:0]    issue_val;
    logic             raw;
    logic             issue;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    // r0 never has a pending result; every other register gets its own down-counter.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W    (CW)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (issue && (id_wr_reg == REG_BITS'(r))),
            .hold     (freeze),
            .load_val (issue_val),
            .cnt      (cnt[r])
        );
    end

    // Source read muxes and the consumer-dependent distance threshold.
    always_comb begin
        rs_cnt = cnt[id_rs];
        rt_cnt = cnt[id_rt];
        thr    = (id_branch && BR_ID) ? '0 : CW'(1);
    end

    // Hazard decision and pipeline control, zero latency from ID inputs.
    always_comb begin
        raw       = id_valid && !id_kill &&
                    ((id_use_rs && (rs_cnt > thr)) || (id_use_rt && (rt_cnt > thr)));
        freeze    = mem_busy;
        hold      = mem_busy || raw;
        id_flush  = raw && !mem_busy;
        issue     = id_valid && !id_kill && !hold && id_wr_en && (id_wr_reg != '0);
        issue_val = id_is_load ? CW'(LOAD_LAT + 1) : CW'(1);
    end

    // Saturating count of cycles lost to RAW stalls; frozen cycles are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (raw && !freeze && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default, LOAD_LAT=3 and CNT_W=4 instances share the ID stimulus.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic        id_kill;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_branch;
    logic        id_wr_en;
    logic [4:0]  id_wr_reg;
    logic        id_is_load;
    logic        mem_busy;

    logic        hold0, flush0, freeze0;
    logic [15:0] sc0;
    logic        hold3, flush3, freeze3;
    logic [15:0] sc3;
    logic        hold4, flush4, freeze4;
    logic [3:0]  sc4;

    int total;
    int bad;

    hazard_scoreboard u_dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .mem_busy(mem_busy),
        .hold(hold0), .id_flush(flush0), .freeze(freeze0), .stall_cnt(sc0)
    );

    hazard_scoreboard #(.LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .mem_busy(mem_busy),
        .hold(hold3), .id_flush(flush3), .freeze(freeze3), .stall_cnt(sc3)
    );

    hazard_scoreboard #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .mem_busy(mem_busy),
        .hold(hold4), .id_flush(flush4), .freeze(freeze4), .stall_cnt(sc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one instruction in ID for the next cycle; outputs are settled on return.
    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic br, input logic we, input logic [4:0] wd, input logic ld,
                       input logic kill, input logic busy);
        @(negedge clk);
        id_valid   = 1'b1;
        id_kill    = kill;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_branch  = br;
        id_wr_en   = we;
        id_wr_reg  = wd;
        id_is_load = ld;
        mem_busy   = busy;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 1'b0; id_kill = 1'b0; id_rs = '0; id_rt = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_branch = 1'b0;
        id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic lw(input logic [4:0] d);
        ins(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        ins(s, t, 1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic beq(input logic [4:0] s, input logic [4:0] t);
        ins(s, t, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        total++; if (hold0 !== 1'b0) begin $display("FAIL rst_hold got=%b want=0", hold0); bad++; end
        total++; if (flush0 !== 1'b0) begin $display("FAIL rst_flush got=%b want=0", flush0); bad++; end
        total++; if (freeze0 !== 1'b0) begin $display("FAIL rst_freeze got=%b want=0", freeze0); bad++; end
        total++; if (sc0 !== 16'd0) begin $display("FAIL rst_stall_cnt got=%0d want=0", sc0); bad++; end
        mem_busy = 1'b1;
        #1;
        total++; if (freeze0 !== 1'b1) begin $display("FAIL rst_busy_freeze got=%b want=1", freeze0); bad++; end
        total++; if (hold0 !== 1'b1) begin $display("FAIL rst_busy_hold got=%b want=1", hold0); bad++; end
        total++; if (flush0 !== 1'b0) begin $display("FAIL rst_busy_flush got=%b want=0", flush0); bad++; end
        mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        lw(5'd2);
        total++; if (hold0 !== 1'b0) begin $display("FAIL lu_lw_hold got=%b want=0", hold0); bad++; end
        add(5'd3, 5'd2, 5'd4);
        total++; if (hold0 !== 1'b1) begin $display("FAIL lu_stall_hold got=%b want=1", hold0); bad++; end
        total++; if (flush0 !== 1'b1) begin $display("FAIL lu_stall_flush got=%b want=1", flush0); bad++; end
        total++; if (freeze0 !== 1'b0) begin $display("FAIL lu_stall_freeze got=%b want=0", freeze0); bad++; end
        add(5'd3, 5'd2, 5'd4);
        total++; if (hold0 !== 1'b0) begin $display("FAIL lu_go_hold got=%b want=0", hold0); bad++; end
        total++; if (flush0 !== 1'b0) begin $display("FAIL lu_go_flush got=%b want=0", flush0); bad++; end
        total++; if (sc0 !== 16'd1) begin $display("FAIL lu_stall_cnt got=%0d want=1", sc0); bad++; end
        beq(5'd3, 5'd0);
        total++; if (hold0 !== 1'b1) begin $display("FAIL lu_add_issued got=%b want=1", hold0); bad++; end
        beq(5'd3, 5'd0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL lu_beq_go got=%b want=0", hold0); bad++; end
    endtask

    task automatic test_branch();
        do_reset();
        add(5'd2, 5'd0, 5'd0);
        beq(5'd2, 5'd5);
        total++; if (hold0 !== 1'b1) begin $display("FAIL br_alu_stall got=%b want=1", hold0); bad++; end
        beq(5'd2, 5'd5);
        total++; if (hold0 !== 1'b0) begin $display("FAIL br_alu_go got=%b want=0", hold0); bad++; end
        total++; if (sc0 !== 16'd1) begin $display("FAIL br_alu_cnt got=%0d want=1", sc0); bad++; end
        lw(5'd2);
        beq(5'd2, 5'd5);
        total++; if (hold0 !== 1'b1) begin $display("FAIL br_lw_stall1 got=%b want=1", hold0); bad++; end
        beq(5'd2, 5'd5);
        total++; if (hold0 !== 1'b1) begin $display("FAIL br_lw_stall2 got=%b want=1", hold0); bad++; end
        beq(5'd2, 5'd5);
        total++; if (hold0 !== 1'b0) begin $display("FAIL br_lw_go got=%b want=0", hold0); bad++; end
        total++; if (sc0 !== 16'd3) begin $display("FAIL br_lw_cnt got=%0d want=3", sc0); bad++; end
    endtask

    task automatic test_mem_busy();
        do_reset();
        lw(5'd2);
        for (int i = 0; i < 3; i++) begin
            ins(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
            total++; if (freeze0 !== 1'b1) begin $display("FAIL mb_freeze[%0d] got=%b want=1", i, freeze0); bad++; end
            total++; if (hold0 !== 1'b1) begin $display("FAIL mb_hold[%0d] got=%b want=1", i, hold0); bad++; end
            total++; if (flush0 !== 1'b0) begin $display("FAIL mb_flush[%0d] got=%b want=0", i, flush0); bad++; end
        end
        add(5'd3, 5'd2, 5'd4);
        total++; if (flush0 !== 1'b1) begin $display("FAIL mb_bubble got=%b want=1", flush0); bad++; end
        total++; if (freeze0 !== 1'b0) begin $display("FAIL mb_unfreeze got=%b want=0", freeze0); bad++; end
        add(5'd3, 5'd2, 5'd4);
        total++; if (hold0 !== 1'b0) begin $display("FAIL mb_go got=%b want=0", hold0); bad++; end
        total++; if (sc0 !== 16'd1) begin $display("FAIL mb_cnt got=%0d want=1", sc0); bad++; end
    endtask

    task automatic test_r0_and_kill();
        do_reset();
        lw(5'd0);
        add(5'd3, 5'd0, 5'd0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL r0_add got=%b want=0", hold0); bad++; end
        beq(5'd0, 5'd0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL r0_beq got=%b want=0", hold0); bad++; end
        lw(5'd2);
        ins(5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL kill_hold got=%b want=0", hold0); bad++; end
        total++; if (flush0 !== 1'b0) begin $display("FAIL kill_flush got=%b want=0", flush0); bad++; end
        beq(5'd3, 5'd0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL kill_no_issue got=%b want=0", hold0); bad++; end
        lw(5'd2);
        ins(5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        add(5'd5, 5'd2, 5'd0);
        total++; if (hold0 !== 1'b0) begin $display("FAIL kill_ages got=%b want=0", hold0); bad++; end
        total++; if (sc0 !== 16'd0) begin $display("FAIL kill_cnt got=%0d want=0", sc0); bad++; end
    endtask

    task automatic test_long_load();
        do_reset();
        lw(5'd7);
        for (int i = 0; i < 3; i++) begin
            add(5'd8, 5'd7, 5'd0);
            total++; if (hold3 !== 1'b1) begin $display("FAIL ll_stall[%0d] got=%b want=1", i, hold3); bad++; end
        end
        add(5'd8, 5'd7, 5'd0);
        total++; if (hold3 !== 1'b0) begin $display("FAIL ll_go got=%b want=0", hold3); bad++; end
        total++; if (sc3 !== 16'd3) begin $display("FAIL ll_cnt got=%0d want=3", sc3); bad++; end
        do_reset();
        lw(5'd7);
        add(5'd7, 5'd0, 5'd0);
        total++; if (hold3 !== 1'b0) begin $display("FAIL waw_add got=%b want=0", hold3); bad++; end
        add(5'd9, 5'd7, 5'd0);
        total++; if (hold3 !== 1'b0) begin $display("FAIL waw_use got=%b want=0", hold3); bad++; end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        lw(5'd2);
        beq(5'd2, 5'd0);
        beq(5'd2, 5'd0);
        total++; if (hold0 !== 1'b1) begin $display("FAIL rms_pre_hold got=%b want=1", hold0); bad++; end
        total++; if (sc0 !== 16'd1) begin $display("FAIL rms_pre_cnt got=%0d want=1", sc0); bad++; end
        rst = 1'b1;
        #1;
        total++; if (hold0 !== 1'b0) begin $display("FAIL rms_hold got=%b want=0", hold0); bad++; end
        total++; if (flush0 !== 1'b0) begin $display("FAIL rms_flush got=%b want=0", flush0); bad++; end
        total++; if (sc0 !== 16'd0) begin $display("FAIL rms_cnt got=%0d want=0", sc0); bad++; end
        total++; if (hold3 !== 1'b0) begin $display("FAIL rms_hold3 got=%b want=0", hold3); bad++; end
        rst = 1'b0;
        beq(5'd2, 5'd0);
        total++; if (hold3 !== 1'b0) begin $display("FAIL rms_cleared3 got=%b want=0", hold3); bad++; end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            lw(5'd2);
            beq(5'd2, 5'd0);
            beq(5'd2, 5'd0);
            beq(5'd2, 5'd0);
            if (i == 6) begin
                total++; if (sc4 !== 4'd14) begin $display("FAIL sat_mid got=%0d want=14", sc4); bad++; end
            end
        end
        total++; if (sc4 !== 4'd15) begin $display("FAIL sat_end got=%0d want=15", sc4); bad++; end
        total++; if (sc0 !== 16'd20) begin $display("FAIL sat_wide got=%0d want=20", sc0); bad++; end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_r0_and_kill();
        test_long_load();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
